// File: rtl/bus_rr_arbiter_matrix.sv
// Shared single-channel bus: registered round-robin arbiter with optional burst limit,
// owner-muxed address/write/data, upper-address slave decode and one-cycle read return.
module bus_rr_arbiter_matrix #(
   parameter int NM        = 2,
   parameter int NS        = 2,
   parameter int AW        = 16,
   parameter int DW        = 64,
   parameter int SB        = 2,
   parameter int MAX_BURST = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NM-1:0]    m_req,
   input  logic [NM-1:0]    m_wr,
   input  logic [NM*AW-1:0] m_address,
   input  logic [NM*DW-1:0] m_dout,
   input  logic [NS*DW-1:0] s_dout,
   output logic [NM-1:0]    m_grant,
   output logic [DW-1:0]    m_din,
   output logic [NS-1:0]    s_sel,
   output logic [AW-1:0]    s_address,
   output logic             s_wr,
   output logic [DW-1:0]    s_din
);

   localparam int IW = (NM > 1) ? $clog2(NM) : 1;
   localparam int CW = $clog2(MAX_BURST + 2);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] OWNED = 1'b1;

   logic [0:0]    state, state_nxt;
   logic [IW-1:0] owner, owner_nxt;
   logic [IW-1:0] ptr, ptr_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [NS-1:0] rd_sel;
   logic [IW-1:0] k1;
   logic [IW:0]   from_ptr, from_k1;
   logic          others, hold;
   logic [SB-1:0] idx;

   // {found, index} of the first requester at or after start, wrapping modulo NM
   function automatic logic [IW:0] find_req(input logic [NM-1:0] req, input logic [IW-1:0] start);
      int j;
      find_req = '0;
      for (int i = NM - 1; i >= 0; i--) begin
         j = (int'(start) + i) % NM;
         if (req[j]) find_req = {1'b1, IW'(j)};
      end
   endfunction

   always_comb begin
      k1       = IW'((int'(owner) + 1) % NM);
      from_ptr = find_req(m_req, ptr);
      from_k1  = find_req(m_req, k1);
      others   = |(m_req & ~(NM'(1) << owner));
      hold     = m_req[owner] && (MAX_BURST == 0 || int'(cnt) < MAX_BURST - 1 || !others);
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (from_ptr[IW]) begin
               state_nxt = OWNED;
               owner_nxt = from_ptr[IW-1:0];
               cnt_nxt   = '0;
            end
         end
         default: begin
            if (hold) begin
               cnt_nxt = (cnt == '1) ? cnt : cnt + CW'(1);
            end else begin
               // handoff in the same edge, so the bus never sits idle between owners
               ptr_nxt = k1;
               cnt_nxt = '0;
               if (from_k1[IW]) owner_nxt = from_k1[IW-1:0];
               else             state_nxt = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         owner  <= '0;
         ptr    <= '0;
         cnt    <= '0;
         rd_sel <= '0;
      end else begin
         state  <= state_nxt;
         owner  <= owner_nxt;
         ptr    <= ptr_nxt;
         cnt    <= cnt_nxt;
         rd_sel <= s_sel;
      end
   end

   assign m_grant = (state == OWNED) ? (NM'(1) << owner) : '0;

   always_comb begin
      s_address = '0;
      s_wr      = 1'b0;
      s_din     = '0;
      if (state == OWNED) begin
         s_address = m_address[owner*AW +: AW];
         s_wr      = m_wr[owner];
         s_din     = m_dout[owner*DW +: DW];
      end
   end

   // decode values at or above NS match no slave, so writes drop and reads return 0
   assign idx = s_address[AW-1 -: SB];

   always_comb begin
      s_sel = '0;
      for (int j = 0; j < NS; j++)
         if (state == OWNED && idx == SB'(j)) s_sel[j] = 1'b1;
   end

   always_comb begin
      m_din = '0;
      for (int j = 0; j < NS; j++)
         if (rd_sel[j]) m_din = m_din | s_dout[j*DW +: DW];
   end

endmodule

// File: tb/tb_bus_rr_arbiter_matrix.sv
// Directed bench: an unlimited-burst three-slave instance for routing/decode/reset,
// plus a MAX_BURST=4 instance sharing the masters for the burst-limit rotation.
module tb_bus_rr_arbiter_matrix;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    m_req, m_wr;
   logic [31:0]   m_address;
   logic [127:0]  m_dout;
   logic [191:0]  s_dout;

   logic [1:0]    m_grant;
   logic [63:0]   m_din, s_din;
   logic [2:0]    s_sel;
   logic [15:0]   s_address;
   logic          s_wr;

   logic [1:0]    gb;
   logic [63:0]   dinb, sdinb;
   logic [1:0]    selb;
   logic [15:0]   addrb;
   logic          wrb;

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] sb_q[$];

   always #5 clk = ~clk;

   bus_rr_arbiter_matrix #(.NM(2), .NS(3), .AW(16), .DW(64), .SB(2), .MAX_BURST(0)) dut (
      .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_wr(m_wr), .m_address(m_address),
      .m_dout(m_dout), .s_dout(s_dout), .m_grant(m_grant), .m_din(m_din), .s_sel(s_sel),
      .s_address(s_address), .s_wr(s_wr), .s_din(s_din));

   bus_rr_arbiter_matrix #(.NM(2), .NS(2), .AW(16), .DW(64), .SB(2), .MAX_BURST(4)) dutb (
      .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_wr(m_wr), .m_address(m_address),
      .m_dout(m_dout), .s_dout(s_dout[127:0]), .m_grant(gb), .m_din(dinb), .s_sel(selb),
      .s_address(addrb), .s_wr(wrb), .s_din(sdinb));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_rd(input string tag);
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL %s: scoreboard empty, expected an entry", tag);
      end else begin
         check(tag, m_din, sb_q.pop_front());
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      m_req     = 2'b11;
      m_wr      = 2'b00;
      m_address = '0;
      m_dout    = '0;
      s_dout[0*64 +: 64] = 64'h1111_0000_AAAA_0000;
      s_dout[1*64 +: 64] = 64'h2222_0001_BBBB_0001;
      s_dout[2*64 +: 64] = 64'h3333_0002_CCCC_0002;
      m_address[0 +: 16]  = 16'h4000;
      m_address[16 +: 16] = 16'h8000;

      // reset holds everything at zero even with requests pending
      repeat (2) tick();
      check("rst_grant", m_grant, 0);
      check("rst_din", m_din, 0);
      check("rst_sel", s_sel, 0);
      check("rst_addr", s_address, 0);
      check("rst_wr", s_wr, 0);
      check("rst_sdin", s_din, 0);

      // first grant one edge after the request
      reset_n = 1'b1;
      m_req   = 2'b01;
      #1 check("lat_nogrant", m_grant, 0);
      tick();
      check("t1_grant", m_grant, 2'b01);
      check("t1_addr", s_address, 16'h4000);
      check("t1_sel", s_sel, 3'b010);

      // write then reads with one-cycle return
      m_wr = 2'b01;
      m_dout[0 +: 64] = 64'hA5;
      #1;
      check("t2_sel", s_sel, 3'b010);
      check("t2_wr", s_wr, 1);
      check("t2_sdin", s_din, 64'hA5);
      tick();
      m_wr = 2'b00;
      sb_q.push_back(s_dout[1*64 +: 64]);
      #1 tick();
      pop_rd("t2_rd1");
      m_address[0 +: 16] = 16'h8000;
      sb_q.push_back(s_dout[2*64 +: 64]);
      #1 check("t2_rd_prev", m_din, s_dout[1*64 +: 64]);
      tick();
      pop_rd("t2_rd2");

      // unlimited burst holds; release hands off with no idle cycle
      m_req = 2'b11;
      m_address[16 +: 16] = 16'h2000;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t3_hold", m_grant, 2'b01);
      end
      m_req = 2'b10;
      #1 check("t3_pre", m_grant, 2'b01);
      tick();
      check("t3_handoff", m_grant, 2'b10);
      check("t3_addr", s_address, 16'h2000);
      check("t3_sel", s_sel, 3'b001);

      // burst limit of 4 rotates the grant on dutb
      reset_n = 1'b0;
      #1 reset_n = 1'b1;
      m_req = 2'b11;
      for (int i = 0; i < 12; i++) begin
         logic [1:0] e;
         e = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
         tick();
         check("t4_burst", gb, e);
      end
      check("t4_unlim", m_grant, 2'b01);

      // out-of-range decode drops the access
      m_address[0 +: 16] = 16'hC000;
      m_wr = 2'b01;
      #1;
      check("t5_sel", s_sel, 3'b000);
      check("t5_wr", s_wr, 1);
      sb_q.push_back(64'h0);
      tick();
      pop_rd("t5_rd");
      m_wr = 2'b00;

      // move pointer to 1, read, then reset mid-transfer
      m_req = 2'b10;
      tick();
      check("t6_own1", m_grant, 2'b10);
      m_address[16 +: 16] = 16'h4000;
      m_req = 2'b11;
      sb_q.push_back(s_dout[1*64 +: 64]);
      #1 tick();
      pop_rd("t6_rd");
      check("t6_keep", m_grant, 2'b10);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_grant", m_grant, 0);
      check("t6_rst_din", m_din, 0);
      check("t6_rst_sel", s_sel, 0);
      check("t6_rst_addr", s_address, 0);
      #1 reset_n = 1'b1;
      #1 check("t6_nogrant", m_grant, 0);
      tick();
      check("t6_ptr0", m_grant, 2'b01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
